// File: rtl/dma_mem_ctrl.sv
// dma_mem_ctrl
// Command sequencer for the dma_mem_wr / dma_mem_rd engines that share one
// peripheral memory. One command (op, addr, len, timeout) is accepted at a
// time, latched, and used to run the selected engine's 4-phase req/ack
// handshake. Software sees busy, a one-cycle done pulse, a sticky error and a
// completed-command counter.
//
// Ports
//   clk_i, rst_ni              clock; asynchronous active-low reset
//   cmd_start_i                one-cycle command strobe
//   cmd_op_i                   0 = write to memory, 1 = read from memory
//   cmd_addr_i / cmd_len_i     start address / read length in words
//   cmd_tout_i                 timeout in cycles, 0 disables it
//   wr_req_o/wr_ack_i/wr_addr_o          write engine handshake + address
//   rd_req_o/rd_ack_i/rd_addr_o/rd_len_o read engine handshake + addr/len
//   busy_o, done_o, err_o, cmd_cnt_o     status to software
`timescale 1ns/1ps

module dma_mem_ctrl #(
    parameter int MEM_AW = 16,
    parameter int TOUT_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_start_i,
    input  logic              cmd_op_i,
    input  logic [MEM_AW-1:0] cmd_addr_i,
    input  logic [MEM_AW-1:0] cmd_len_i,
    input  logic [TOUT_W-1:0] cmd_tout_i,
    output logic              wr_req_o,
    input  logic              wr_ack_i,
    output logic [MEM_AW-1:0] wr_addr_o,
    output logic              rd_req_o,
    input  logic              rd_ack_i,
    output logic [MEM_AW-1:0] rd_addr_o,
    output logic [MEM_AW-1:0] rd_len_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  cmd_cnt_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Reset asserts asynchronously but is released through two flops so the
    // whole controller leaves reset on a clean clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [1:0]        state_q, state_d;
    logic              op_q;
    logic [MEM_AW-1:0] addr_q;
    logic [MEM_AW-1:0] len_q;
    logic [TOUT_W-1:0] tout_q;
    logic [TOUT_W-1:0] tcnt_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic sel_ack;
    logic tout_hit;
    logic reject;
    logic accept;
    logic err_set;

    // Only the engine chosen by the latched op is listened to; the other
    // engine's ack is ignored for the whole command.
    assign sel_ack  = op_q ? rd_ack_i : wr_ack_i;
    // Counter starts at 0 on state entry, so hitting tout-1 means the state
    // has been occupied for exactly tout cycles.
    assign tout_hit = (tout_q != '0) && (tcnt_q == tout_q - TOUT_W'(1));
    // An engine still showing ack has not drained its previous transfer;
    // a zero-length read has nothing to do.
    assign reject   = wr_ack_i | rd_ack_i | (cmd_op_i & (cmd_len_i == '0));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        accept  = 1'b0;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start_i) begin
                    if (reject) begin
                        err_set = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (sel_ack) begin
                    state_d = ST_RUN;
                end else if (tout_hit) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A started engine cannot be aborted: a timeout here only
                // flags the error and keeps waiting for ack to fall.
                if (!sel_ack) begin
                    state_d = ST_DONE;
                end else if (tout_hit) begin
                    err_set = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            tout_q  <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;

            if (accept) begin
                op_q   <= cmd_op_i;
                addr_q <= cmd_addr_i;
                len_q  <= cmd_len_i;
                tout_q <= cmd_tout_i;
            end

            if (state_d != state_q) begin
                tcnt_q <= '0;
            end else if (state_q == ST_REQ || state_q == ST_RUN) begin
                tcnt_q <= tcnt_q + TOUT_W'(1);
            end

            if (accept) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end

            if (state_q == ST_DONE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // All outputs are decoded from registers: no input reaches an output
    // combinationally, and req drops on the same edge that enters ST_RUN.
    assign wr_req_o  = (state_q == ST_REQ) & ~op_q;
    assign rd_req_o  = (state_q == ST_REQ) &  op_q;
    assign wr_addr_o = addr_q;
    assign rd_addr_o = addr_q;
    assign rd_len_o  = len_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_DONE);
    assign err_o     = err_q;
    assign cmd_cnt_o = cnt_q;

endmodule

// File: tb/tb_dma_mem_ctrl.sv
// Self-checking bench for dma_mem_ctrl. A behavioural engine answers req with
// ack after a chosen delay and holds it for a chosen number of cycles; the
// expected req/busy/done/err/count for each command are computed from those
// delays and the timeout with plain arithmetic.
`timescale 1ns/1ps

module tb_dma_mem_ctrl;

    localparam int MEM_AW = 16;
    localparam int TOUT_W = 16;
    localparam int CNT_W  = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              cmd_start_i;
    logic              cmd_op_i;
    logic [MEM_AW-1:0] cmd_addr_i;
    logic [MEM_AW-1:0] cmd_len_i;
    logic [TOUT_W-1:0] cmd_tout_i;
    logic              wr_req_o;
    logic              wr_ack_i;
    logic [MEM_AW-1:0] wr_addr_o;
    logic              rd_req_o;
    logic              rd_ack_i;
    logic [MEM_AW-1:0] rd_addr_o;
    logic [MEM_AW-1:0] rd_len_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [CNT_W-1:0]  cmd_cnt_o;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_cnt  = '0;

    always #5 clk_i = ~clk_i;

    dma_mem_ctrl #(
        .MEM_AW (MEM_AW),
        .TOUT_W (TOUT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_start_i (cmd_start_i),
        .cmd_op_i    (cmd_op_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_tout_i  (cmd_tout_i),
        .wr_req_o    (wr_req_o),
        .wr_ack_i    (wr_ack_i),
        .wr_addr_o   (wr_addr_o),
        .rd_req_o    (rd_req_o),
        .rd_ack_i    (rd_ack_i),
        .rd_addr_o   (rd_addr_o),
        .rd_len_o    (rd_len_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .cmd_cnt_o   (cmd_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {27'd0, wr_req_o, rd_req_o, busy_o, done_o, err_o}, 32'd0);
        check({tag, "_addr"}, {wr_addr_o, rd_addr_o}, 32'd0);
        check({tag, "_len_cnt"}, {8'd0, rd_len_o, cmd_cnt_o}, 32'd0);
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        cmd_start_i = 1'b0;
        wr_ack_i    = 1'b0;
        rd_ack_i    = 1'b0;
        repeat (2) @(negedge clk_i);
        check_all_zero("in_reset");
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        exp_cnt = '0;
    endtask

    // Start a command that must be refused; the acks given are held during
    // the start so an engine that has not drained forces a reject.
    task automatic reject_cmd(input logic op, input logic [15:0] len,
                              input logic wa, input logic ra);
        logic seen;
        seen        = 1'b0;
        wr_ack_i    = wa;
        rd_ack_i    = ra;
        cmd_op_i    = op;
        cmd_len_i   = len;
        cmd_addr_i  = 16'($urandom);
        cmd_tout_i  = '0;
        cmd_start_i = 1'b1;
        @(negedge clk_i);
        cmd_start_i = 1'b0;
        check("rej_err", {31'd0, err_o}, 32'd1);
        check("rej_busy", {31'd0, busy_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (wr_req_o || rd_req_o || busy_o) seen = 1'b1;
        end
        check("rej_noreq", {31'd0, seen}, 32'd0);
        check("rej_cnt", {24'd0, cmd_cnt_o}, {24'd0, exp_cnt});
        wr_ack_i = 1'b0;
        rd_ack_i = 1'b0;
    endtask

    // Run one accepted command. The engine raises ack ack_dly cycles after
    // it first sees req (if req is still up) and drops it hold cycles later.
    task automatic run_cmd(input logic op, input logic [15:0] addr, input logic [15:0] len,
                           input logic [15:0] tout, input int ack_dly, input int hold,
                           input bit noise);
        bit req_to, run_to, acked, addr_ok, sel_req, oth_req;
        int exp_busy, req_hi, oth_hi, busy_n, done_n, done_at;
        req_to   = (tout != 0) && (int'(tout) < ack_dly);
        run_to   = !req_to && (tout != 0) && (int'(tout) < hold);
        exp_busy = req_to ? int'(tout) : ack_dly + hold + 1;
        acked = 1'b0; addr_ok = 1'b1;
        req_hi = 0; oth_hi = 0; busy_n = 0; done_n = 0; done_at = -1;

        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        cmd_tout_i  = tout;
        cmd_start_i = 1'b1;
        for (int s = 1; s <= exp_busy + 4; s++) begin
            @(negedge clk_i);
            cmd_start_i = 1'b0;
            sel_req = op ? rd_req_o : wr_req_o;
            oth_req = op ? wr_req_o : rd_req_o;
            if (sel_req) req_hi++;
            if (oth_req) oth_hi++;
            if (busy_o) begin
                busy_n++;
                if ((op ? rd_addr_o : wr_addr_o) != addr) addr_ok = 1'b0;
                if (op && rd_len_o != len) addr_ok = 1'b0;
            end
            if (done_o) begin
                done_n++;
                done_at = s;
            end
            if (s == ack_dly && sel_req) begin
                acked = 1'b1;
                if (op) rd_ack_i = 1'b1; else wr_ack_i = 1'b1;
            end else if (acked && s == ack_dly + hold) begin
                if (op) rd_ack_i = 1'b0; else wr_ack_i = 1'b0;
            end
            // Stray starts and unselected-engine ack while busy must be ignored.
            if (noise && s < exp_busy) begin
                cmd_start_i = ($urandom_range(0, 2) == 0);
                cmd_addr_i  = 16'($urandom);
                cmd_len_i   = 16'($urandom);
                if (op) wr_ack_i = 1'($urandom); else rd_ack_i = 1'($urandom);
            end else begin
                if (op) wr_ack_i = 1'b0; else rd_ack_i = 1'b0;
            end
        end
        wr_ack_i = 1'b0;
        rd_ack_i = 1'b0;
        if (!req_to) exp_cnt++;

        check("req_cycles", req_hi, req_to ? int'(tout) : ack_dly);
        check("other_req", oth_hi, 0);
        check("busy_cycles", busy_n, exp_busy);
        check("done_pulses", done_n, req_to ? 0 : 1);
        if (!req_to) check("done_at", done_at, ack_dly + hold + 1);
        check("err", {31'd0, err_o}, {31'd0, req_to | run_to});
        check("cmd_cnt", {24'd0, cmd_cnt_o}, {24'd0, exp_cnt});
        check("addr_len_hold", {31'd0, addr_ok}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        op;
        logic [15:0] len, tout;
        int          ad, hd;

        cmd_op_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0; cmd_tout_i = '0;
        do_reset();
        check_all_zero("after_reset");

        // Basic write and read transfers
        run_cmd(1'b0, 16'h0010, 16'h0000, 16'd0, 2, 5, 1'b0);
        run_cmd(1'b1, 16'h0020, 16'h0008, 16'd0, 1, 8, 1'b0);

        // Rejects: zero-length read, start while an engine still acks
        reject_cmd(1'b1, 16'h0000, 1'b0, 1'b0);
        reject_cmd(1'b0, 16'h0005, 1'b1, 1'b0);
        reject_cmd(1'b1, 16'h0004, 1'b0, 1'b1);
        run_cmd(1'b0, 16'h0033, 16'h0000, 16'd0, 1, 2, 1'b0);

        // Timeouts: engine silent (REQ timeout), engine stuck in ack (RUN timeout)
        run_cmd(1'b1, 16'h0030, 16'h0004, 16'd5, 100, 1, 1'b0);
        run_cmd(1'b1, 16'h0040, 16'h0004, 16'd5, 1, 20, 1'b0);

        // Fastest handshake and noisy inputs during a command
        run_cmd(1'b0, 16'h0044, 16'h0000, 16'd0, 1, 1, 1'b0);
        run_cmd(1'b1, 16'h0050, 16'h0006, 16'd0, 3, 8, 1'b1);
        run_cmd(1'b0, 16'h0060, 16'h0000, 16'd0, 4, 6, 1'b1);

        // Reset while in ST_REQ drops req at once
        cmd_op_i = 1'b1; cmd_addr_i = 16'h0070; cmd_len_i = 16'd3; cmd_tout_i = '0;
        cmd_start_i = 1'b1;
        @(negedge clk_i);
        cmd_start_i = 1'b0;
        check("pre_reset_req", {31'd0, rd_req_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check_all_zero("reset_in_req");
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        exp_cnt = '0;
        check_all_zero("post_mid_reset");

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                reject_cmd(op, 16'($urandom_range(1, 100)), 1'($urandom), 1'b1);
            end else if (op && $urandom_range(0, 4) == 0) begin
                reject_cmd(1'b1, 16'h0000, 1'b0, 1'b0);
            end else begin
                len = op ? 16'($urandom_range(1, 65535)) : 16'($urandom);
                ad  = $urandom_range(1, 6);
                hd  = $urandom_range(1, 10);
                tout = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 12)) : 16'd0;
                if (int'(tout) == ad || int'(tout) == hd) tout = 16'd0;
                run_cmd(op, 16'($urandom), len, tout, ad, hd, 1'($urandom));
            end
        end

        // Counter wrap with CNT_W = 8
        do_reset();
        for (int i = 0; i < 255; i++) begin
            run_cmd(1'($urandom), 16'(i), 16'd1, 16'd0, 1, 1, 1'b0);
        end
        check("cnt_255", {24'd0, cmd_cnt_o}, 32'd255);
        run_cmd(1'b0, 16'h00ff, 16'd1, 16'd0, 1, 1, 1'b0);
        check("cnt_wrap", {24'd0, cmd_cnt_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
